// File: rtl/data_req_axi_responder_if.sv
// AXI4 bus bundle between the uncached data responder (master) and the crossbar (slave).
// Single-beat subset: AR/R/AW/W/B channels, 4-bit IDs, no user/qos/lock/cache fields.
interface data_req_axi_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/data_req_axi_responder.sv
// Uncached data-side responder: turns one pipeline load/store at a time into a single-beat AXI4 transaction.
// Optional macro DATA_REQ_BUS_ERR_EN adds data_bus_err, flagging SLVERR/DECERR responses alongside data_data_ok.
module data_req_axi_responder #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_valid,
    input  logic                data_op,
    input  logic [2:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
`ifdef DATA_REQ_BUS_ERR_EN
    output logic                data_bus_err,
`endif
    data_req_axi_responder_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AW_W,
        WR_B,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                data_ok_q, data_ok_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                aw_done, w_done;
    logic                bus_err_q, bus_err_d;

    assign data_addr_ok = (state_q == IDLE) && data_valid;

    // A dropped awvalid/wvalid doubles as that channel's done flag, so both
    // channels are done once neither valid will still be high next cycle.
    assign aw_done = !awvalid_q || axi.awready;
    assign w_done  = !wvalid_q || axi.wready;

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_rdata_d = data_rdata_q;
        data_ok_d    = 1'b0;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        bus_err_d    = bus_err_q;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    size_d    = data_size;
                    wstrb_d   = data_wstrb;
                    addr_d    = data_addr;
                    wdata_d   = data_wdata;
                    arvalid_d = !data_op;
                    awvalid_d = data_op;
                    wvalid_d  = data_op;
                    state_d   = data_op ? WR_AW_W : RD_AR;
                end
            end
            RD_AR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (axi.rvalid) begin
                    rready_d     = 1'b0;
                    data_rdata_d = axi.rdata;
                    bus_err_d    = axi.rresp[1];
                    data_ok_d    = 1'b1;
                    state_d      = RESP;
                end
            end
            WR_AW_W: begin
                awvalid_d = awvalid_q && !axi.awready;
                wvalid_d  = wvalid_q && !axi.wready;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (axi.bvalid) begin
                    bready_d  = 1'b0;
                    bus_err_d = axi.bresp[1];
                    data_ok_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            size_q       <= '0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_rdata_q <= '0;
            data_ok_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_rdata_q <= data_rdata_d;
            data_ok_q    <= data_ok_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign data_data_ok = data_ok_q;
    assign data_rdata   = data_rdata_q;

`ifdef DATA_REQ_BUS_ERR_EN
    assign data_bus_err = bus_err_q;
`else
    logic unused_bus_err;
    assign unused_bus_err = bus_err_q ^ axi.rresp[0] ^ axi.bresp[0];
`endif

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = size_q;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = size_q;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_data_req_axi_responder.sv
// Scoreboard bench for data_req_axi_responder: directed requests push expected responses,
// a separate monitor pops and compares them on every data_data_ok.
module tb_data_req_axi_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_valid;
    logic        data_op;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
`ifdef DATA_REQ_BUS_ERR_EN
    logic        data_bus_err;
`endif

    data_req_axi_responder_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    data_req_axi_responder #(.ADDR_W(32), .DATA_W(32), .AXI_ID(4'd1)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_valid   (data_valid),
        .data_op      (data_op),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
`ifdef DATA_REQ_BUS_ERR_EN
        .data_bus_err (data_bus_err),
`endif
        .axi          (axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    logic [31:0] last_load_data = 32'h0;
    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [31:0] r_data_val = 32'h0;
    logic [1:0]  r_resp_val = 2'b00;
    logic [1:0]  b_resp_val = 2'b00;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // AXI slave model: each ready/valid rises once its channel has waited the configured cycles.
    initial begin
        int cnt;
        cnt = 0;
        axi.arready = 1'b0;
        forever begin
            @(negedge clk);
            if (axi.arvalid) begin
                axi.arready = (cnt >= ar_wait);
                cnt++;
            end else begin
                axi.arready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        axi.rvalid = 1'b0;
        axi.rdata  = 32'h0;
        axi.rresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (axi.rready) begin
                axi.rvalid = (cnt >= r_wait);
                axi.rdata  = r_data_val;
                axi.rresp  = r_resp_val;
                cnt++;
            end else begin
                axi.rvalid = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        axi.awready = 1'b0;
        forever begin
            @(negedge clk);
            if (axi.awvalid) begin
                axi.awready = (cnt >= aw_wait);
                cnt++;
            end else begin
                axi.awready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        axi.wready = 1'b0;
        forever begin
            @(negedge clk);
            if (axi.wvalid) begin
                axi.wready = (cnt >= w_wait);
                cnt++;
            end else begin
                axi.wready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (axi.bready) begin
                axi.bvalid = (cnt >= b_wait);
                axi.bresp  = b_resp_val;
                cnt++;
            end else begin
                axi.bvalid = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each completion and watches handshake ordering.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (data_data_ok) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_data_ok", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("data_rdata", data_rdata, e.rdata);
                        if (e.lat >= 0) checkOutput("latency", cycle - e.acc, e.lat);
`ifdef DATA_REQ_BUS_ERR_EN
                        checkOutput("data_bus_err", data_bus_err, e.err);
`endif
                    end
                end
                if (data_addr_ok)
                    checkOutput("addr_ok_only_idle",
                        {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, data_data_ok}, 0);
                if (axi.arvalid || axi.rready)
                    checkOutput("no_ar_aw_overlap", {axi.awvalid, axi.wvalid, axi.bready}, 0);
                if (axi.bready)
                    checkOutput("bready_after_aw_w", {axi.awvalid, axi.wvalid}, 0);
            end
        end
    end

    task automatic applyStimulus(input logic op, input logic [2:0] size, input logic [3:0] strb,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] load_data, input logic [1:0] resp,
                                 input int lat, input bit keep, output int acc);
        exp_t e;
        bit   got;
        got = 1'b0;
        acc = -1;
        @(negedge clk);
        data_valid = 1'b1;
        data_op    = op;
        data_size  = size;
        data_wstrb = strb;
        data_addr  = addr;
        data_wdata = wd;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (data_addr_ok) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            checkOutput("accept_timeout", 0, 1);
            data_valid = 1'b0;
            return;
        end
        acc = cycle;
        if (!op) begin
            r_data_val     = load_data;
            r_resp_val     = resp;
            last_load_data = load_data;
        end else begin
            b_resp_val = resp;
        end
        e.rdata = last_load_data;
        e.err   = resp[1];
        e.acc   = acc;
        e.lat   = lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) data_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) checkOutput("drain_timeout", sb_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int acc, acc2, c0;
        reset      = 1'b1;
        data_valid = 1'b0;
        data_op    = 1'b0;
        data_size  = 3'd0;
        data_wstrb = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
        checkOutput("rst_data_ok", data_data_ok, 0);
        checkOutput("rst_rdata", data_rdata, 0);
        reset = 1'b0;

        $display("[TB] zero-wait load");
        applyStimulus(1'b0, 3'd2, 4'hF, 32'h1C00_0010, 32'h0, 32'hDEAD_BEEF, 2'b00, 3, 1'b0, acc);
        @(negedge clk);
        checkOutput("ld_arvalid_t1", axi.arvalid, 1);
        checkOutput("ld_araddr", axi.araddr, 32'h1C00_0010);
        checkOutput("ld_arsize", axi.arsize, 2);
        checkOutput("ld_arlen", axi.arlen, 0);
        checkOutput("ld_arburst", axi.arburst, 1);
        checkOutput("ld_arid", axi.arid, 1);
        @(negedge clk);
        checkOutput("ld_rready_t2", axi.rready, 1);
        checkOutput("ld_arvalid_t2", axi.arvalid, 0);
        waitDrain();

        $display("[TB] store, awready delayed 3 cycles");
        aw_wait = 3;
        applyStimulus(1'b1, 3'd2, 4'b0011, 32'h0000_1000, 32'h0000_BEEF, 32'h0, 2'b00, 6, 1'b0, acc);
        @(negedge clk);
        checkOutput("st_t1_valids", {axi.awvalid, axi.wvalid}, 2'b11);
        checkOutput("st_awaddr", axi.awaddr, 32'h0000_1000);
        checkOutput("st_wstrb", axi.wstrb, 4'b0011);
        checkOutput("st_wdata", axi.wdata, 32'h0000_BEEF);
        checkOutput("st_fixed", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.wlast},
                    {4'd1, 8'd0, 3'd2, 2'b01, 1'b1});
        for (int t = 2; t <= 4; t++) begin
            @(negedge clk);
            checkOutput("st_wait_aw_w_b", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
        end
        @(negedge clk);
        checkOutput("st_t5_aw_w_b", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
        waitDrain();
        aw_wait = 0;

        $display("[TB] store, wready delayed 2 cycles");
        w_wait = 2;
        applyStimulus(1'b1, 3'd2, 4'hF, 32'h0000_1004, 32'h1234_5678, 32'h0, 2'b00, 5, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        checkOutput("stw_t2_aw_w_b", {axi.awvalid, axi.wvalid, axi.bready}, 3'b010);
        waitDrain();
        w_wait = 0;

        $display("[TB] back-to-back load then store");
        applyStimulus(1'b0, 3'd2, 4'hF, 32'h1C00_0020, 32'h0, 32'hCAFE_F00D, 2'b00, 3, 1'b1, acc);
        applyStimulus(1'b1, 3'd2, 4'hF, 32'h1C00_0024, 32'hA5A5_A5A5, 32'h0, 2'b00, 3, 1'b0, acc2);
        checkOutput("b2b_second_accept", acc2, acc + 4);
        waitDrain();

        $display("[TB] arready backpressure");
        ar_wait = 10;
        applyStimulus(1'b0, 3'd0, 4'h1, 32'h2000_0041, 32'h0, 32'h0000_0077, 2'b00, 13, 1'b1, acc);
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_arvalid", axi.arvalid, 1);
            checkOutput("bp_araddr", axi.araddr, 32'h2000_0041);
            checkOutput("bp_arsize", axi.arsize, 0);
            checkOutput("bp_addr_ok", data_addr_ok, 0);
        end
        data_valid = 1'b0;
        waitDrain();
        ar_wait = 0;

        $display("[TB] reset while waiting for R");
        r_wait = 100;
        applyStimulus(1'b0, 3'd2, 4'hF, 32'h0000_3000, 32'h0, 32'h1111_2222, 2'b00, -1, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pre_rready", axi.rready, 1);
        reset = 1'b1;
        sb_q.delete();
        last_load_data = 32'h0;
        @(negedge clk);
        checkOutput("rst_mid_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
        checkOutput("rst_mid_data_ok", data_data_ok, 0);
        checkOutput("rst_mid_rdata", data_rdata, 0);
        reset  = 1'b0;
        r_wait = 0;
        c0 = cycle;
        applyStimulus(1'b0, 3'd2, 4'hF, 32'h0000_3004, 32'h0, 32'h3333_4444, 2'b00, 3, 1'b0, acc);
        checkOutput("post_reset_accept", acc, c0 + 1);
        waitDrain();

        $display("[TB] error responses");
        applyStimulus(1'b0, 3'd2, 4'hF, 32'h0000_4000, 32'h0, 32'hBADB_AD00, 2'b10, 3, 1'b0, acc);
        waitDrain();
        applyStimulus(1'b0, 3'd2, 4'hF, 32'h0000_4004, 32'h0, 32'h600D_600D, 2'b00, 3, 1'b0, acc);
        waitDrain();
        applyStimulus(1'b1, 3'd2, 4'hF, 32'h0000_4008, 32'h0000_0001, 32'h0, 2'b11, 3, 1'b0, acc);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
